// File: rtl/rom_dl_sequencer.sv
// Steers the HPS ROM download into program/graphics ROM with timed write strobes,
// a wait handshake to the source, and a game reset held across the download.
module rom_dl_sequencer #(
  parameter int PROG_BYTES  = 4096,
  parameter int GFX_BYTES   = 512,
  parameter int WR_CYCLES   = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rst_req,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [13:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic [11:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        prog_we,
  output logic        gfx_we,
  output logic        game_reset,
  output logic [7:0]  checksum,
  output logic        dl_done,
  output logic        dl_err
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, HOLD} state_t;

  localparam logic [13:0] PROG_END = 14'(PROG_BYTES);
  localparam logic [13:0] GFX_END  = 14'(PROG_BYTES + GFX_BYTES);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic [3:0]  wr_cnt;
  logic        active_q;
  logic        rise;
  logic [11:0] gfx_off;

  assign rise    = dl_active & ~active_q;
  assign gfx_off = 12'(dl_addr - PROG_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= 8'(HOLD_CYCLES);
      wr_cnt     <= '0;
      active_q   <= 1'b0;
      dl_wait    <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      prog_we    <= 1'b0;
      gfx_we     <= 1'b0;
      game_reset <= 1'b1;
      checksum   <= '0;
      dl_done    <= 1'b0;
      dl_err     <= 1'b0;
    end else begin
      active_q <= dl_active;
      case (state)
        IDLE: begin
          game_reset <= rst_req;
          if (rise) begin
            state      <= LOAD;
            checksum   <= '0;
            dl_err     <= 1'b0;
            game_reset <= 1'b1;
          end
        end
        LOAD: begin
          game_reset <= 1'b1;
          if (!dl_active) begin
            state    <= HOLD;
            hold_cnt <= 8'(HOLD_CYCLES);
            dl_done  <= 1'b1;
          end else if (dl_wr) begin
            if (dl_addr < PROG_END) begin
              rom_addr <= dl_addr[11:0];
              rom_data <= dl_data;
              prog_we  <= 1'b1;
              dl_wait  <= 1'b1;
              wr_cnt   <= 4'(WR_CYCLES);
              state    <= WRITE;
            end else if (dl_addr < GFX_END) begin
              rom_addr <= gfx_off;
              rom_data <= dl_data;
              gfx_we   <= 1'b1;
              dl_wait  <= 1'b1;
              wr_cnt   <= 4'(WR_CYCLES);
              state    <= WRITE;
            end else begin
              dl_err <= 1'b1;
            end
          end
        end
        WRITE: begin
          // a byte offered while we stall is a protocol violation and is dropped
          if (dl_wr) dl_err <= 1'b1;
          if (wr_cnt == 4'd1) begin
            prog_we  <= 1'b0;
            gfx_we   <= 1'b0;
            dl_wait  <= 1'b0;
            checksum <= checksum + rom_data;
            if (!dl_active) begin
              state    <= HOLD;
              hold_cnt <= 8'(HOLD_CYCLES);
              dl_done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        HOLD: begin
          game_reset <= 1'b1;
          if (rise) begin
            state    <= LOAD;
            checksum <= '0;
            dl_err   <= 1'b0;
          end else if (hold_cnt <= 8'd1) begin
            // hand straight over to the IDLE follower so a held rst_req does not glitch low
            state      <= IDLE;
            hold_cnt   <= '0;
            game_reset <= rst_req;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Bench for rom_dl_sequencer: directed scenarios plus randomized downloads, checked
// every cycle against a transaction-level model of the download sequencing rules.
module tb_rom_dl_sequencer;
  localparam int PROG = 4096, GFX = 512, WRC = 2, HOLDC = 16;

  logic clk = 0, reset = 1, rst_req = 0, dl_active = 0, dl_wr = 0;
  logic [13:0] dl_addr = 0;
  logic [7:0]  dl_data = 0;
  logic dl_wait, prog_we, gfx_we, game_reset, dl_done, dl_err;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data, checksum;

  rom_dl_sequencer #(.PROG_BYTES(PROG), .GFX_BYTES(GFX), .WR_CYCLES(WRC), .HOLD_CYCLES(HOLDC)) dut (
    .clk(clk), .reset(reset), .rst_req(rst_req), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .rom_addr(rom_addr),
    .rom_data(rom_data), .prog_we(prog_we), .gfx_we(gfx_we), .game_reset(game_reset),
    .checksum(checksum), .dl_done(dl_done), .dl_err(dl_err));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit rnd_rst = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: remaining hold time, remaining strobe time and a loading flag stand in for state.
  int hold_left, busy_left;
  bit loading, m_gfx, m_done, m_err, m_gr, prev_a;
  logic [11:0] m_addr;
  logic [7:0]  m_data, m_ck;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_left = HOLDC; busy_left = 0; loading = 0; m_gfx = 0; m_done = 0; m_err = 0;
      m_gr = 1; prev_a = 0; m_addr = 0; m_data = 0; m_ck = 0;
    end else begin
      bit rise;
      rise = dl_active && !prev_a;
      prev_a = dl_active;
      if (hold_left > 0) begin
        if (rise) begin hold_left = 0; loading = 1; m_ck = 0; m_err = 0; end
        else if (hold_left == 1) begin hold_left = 0; m_gr = rst_req; end
        else hold_left--;
      end else if (busy_left > 0) begin
        if (dl_wr) m_err = 1;
        if (busy_left == 1) begin
          busy_left = 0;
          m_ck = m_ck + m_data;
          if (!dl_active) begin loading = 0; hold_left = HOLDC; m_done = 1; end
        end else busy_left--;
      end else if (loading) begin
        if (!dl_active) begin loading = 0; hold_left = HOLDC; m_done = 1; m_gr = 1; end
        else if (dl_wr) begin
          if (int'(dl_addr) < PROG) begin
            m_addr = dl_addr[11:0]; m_data = dl_data; m_gfx = 0; busy_left = WRC;
          end else if (int'(dl_addr) < PROG + GFX) begin
            m_addr = 12'(int'(dl_addr) - PROG); m_data = dl_data; m_gfx = 1; busy_left = WRC;
          end else m_err = 1;
        end
      end else begin
        m_gr = rst_req;
        if (rise) begin loading = 1; m_ck = 0; m_err = 0; m_gr = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset)
      chk("outputs {wait,prog,gfx,grst,done,err,ck,data,addr}",
          {dl_wait, prog_we, gfx_we, game_reset, dl_done, dl_err, checksum, rom_data, rom_addr},
          {busy_left > 0, busy_left > 0 && !m_gfx, busy_left > 0 && m_gfx, m_gr, m_done, m_err,
           m_ck, m_data, m_addr});
  end

  int run = 0;
  int widths[$];
  always @(negedge clk) begin
    if (reset) run = 0;
    else if (prog_we || gfx_we) run++;
    else if (run > 0) begin widths.push_back(run); run = 0; end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_rst) rst_req = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (dl_wait && n < 50) begin cyc(1); n++; end
    chk("dl_wait released within bound", n < 50, 1);
  endtask

  task automatic send(input int a, input int d);
    drain();
    dl_addr = 14'(a); dl_data = 8'(d); dl_wr = 1;
    cyc(1);
    dl_wr = 0;
  endtask

  task automatic start_dl();
    dl_active = 1;
    cyc(1);
  endtask

  task automatic end_dl();
    drain();
    dl_active = 0;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    reset = 0;
    // 1: reset-time hold
    cyc(15);
    chk("reset hold game_reset high", game_reset, 1);
    cyc(1);
    chk("reset hold game_reset released", game_reset, 0);
    chk("dl_done after reset", dl_done, 0);
    chk("checksum after reset", checksum, 0);

    // 2: three program bytes
    widths.delete();
    start_dl();
    send(0, 8'h01); send(1, 8'h02); send(2, 8'h03);
    end_dl();
    chk("pulse count", widths.size(), 3);
    foreach (widths[i]) chk("prog_we width", widths[i], 2);
    chk("checksum 1+2+3", checksum, 8'h06);
    chk("dl_done after download", dl_done, 1);
    cyc(15);
    chk("post-download hold high", game_reset, 1);
    cyc(1);
    chk("post-download hold released", game_reset, 0);

    // 3: graphics byte
    start_dl();
    send(16'h1005, 8'hAA);
    chk("gfx_we", gfx_we, 1);
    chk("prog_we during gfx", prog_we, 0);
    chk("gfx rom_addr", rom_addr, 12'h005);
    chk("gfx rom_data", rom_data, 8'hAA);
    cyc(1);
    chk("gfx_we second cycle", gfx_we, 1);
    cyc(1);
    chk("gfx_we dropped", gfx_we, 0);
    chk("checksum gfx", checksum, 8'hAA);

    // 4: out-of-range byte
    send(16'h1200, 8'h55);
    chk("oob no wait", dl_wait, 0);
    chk("oob no strobe", prog_we | gfx_we, 0);
    chk("oob dl_err", dl_err, 1);
    chk("oob checksum unchanged", checksum, 8'hAA);
    end_dl();
    cyc(3);
    start_dl();
    chk("dl_err cleared on new download", dl_err, 0);
    chk("checksum cleared on new download", checksum, 0);

    // 5: dl_wr during stall, then checksum wrap
    send(0, 8'hFF);
    cyc(1);
    dl_addr = 14'd2; dl_data = 8'h11; dl_wr = 1;
    cyc(1);
    dl_wr = 0;
    chk("violation dl_err", dl_err, 1);
    chk("violation rom_data kept", rom_data, 8'hFF);
    chk("violation checksum", checksum, 8'hFF);
    send(1, 8'hFF);
    end_dl();
    chk("checksum wrap", checksum, 8'hFE);

    // 6: async reset mid-strobe, then rst_req follow in IDLE
    cyc(20);
    start_dl();
    send(0, 8'h33);
    chk("prog_we before reset", prog_we, 1);
    #2 reset = 1;
    #1;
    chk("async reset prog_we", prog_we, 0);
    chk("async reset dl_wait", dl_wait, 0);
    chk("async reset game_reset", game_reset, 1);
    chk("async reset dl_done", dl_done, 0);
    dl_active = 0;
    cyc(1);
    reset = 0;
    cyc(20);
    rst_req = 1;
    cyc(1);
    chk("rst_req follow high", game_reset, 1);
    rst_req = 0;
    cyc(1);
    chk("rst_req follow low", game_reset, 0);

    // randomized downloads with random rst_req and occasional mid-write drop
    rnd_rst = 1;
    for (int k = 0; k < 30; k++) begin
      int nb;
      start_dl();
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        int r, a;
        cyc($urandom_range(0, 2));
        r = $urandom_range(0, 9);
        if (r < 5) a = $urandom_range(0, PROG - 1);
        else if (r < 8) a = $urandom_range(PROG, PROG + GFX - 1);
        else a = $urandom_range(PROG + GFX, 16383);
        send(a, $urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) begin dl_active = 0; cyc(3); end
      else end_dl();
      cyc($urandom_range(0, 25));
    end
    rnd_rst = 0;
    rst_req = 0;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
Sequences the HPS ROM download stream into the game's two on-chip ROM regions: program ROM and character/graphics ROM. It decodes the linear download address and generates timed write strobes with a wait handshake back to the download source. It holds the game core in reset for the whole download and for a fixed settling period afterwards. It sits between the hps_io download outputs and the blockade core, replacing the direct dn_addr/dn_data/dn_wr hookup.

Parameters:
PROG_BYTES, 4096, size of program ROM region; download addresses 0..PROG_BYTES-1.
GFX_BYTES, 512, size of graphics ROM region; download addresses PROG_BYTES..PROG_BYTES+GFX_BYTES-1.
WR_CYCLES, 2, number of clk cycles each write strobe is held high (1..15).
HOLD_CYCLES, 16, number of clk cycles game_reset stays high after the download ends (1..255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rst_req  in  1  user/OSD reset request, level
dl_active  in  1  download of index 0 in progress, level
dl_wr  in  1  single-cycle byte-valid strobe from download source
dl_addr  in  14  byte address of dl_data
dl_data  in  8  download byte
dl_wait  out  1  stall to download source; source issues no new dl_wr while high
rom_addr  out  12  region-relative write address, shared by both regions
rom_data  out  8  write data
prog_we  out  1  program ROM write strobe
gfx_we  out  1  graphics ROM write strobe
game_reset  out  1  reset to game core
checksum  out  8  modulo-256 sum of bytes written in the current/last download
dl_done  out  1  sticky: a download completed since reset
dl_err  out  1  sticky: out-of-range address or protocol violation in current/last download

Behaviour:
- Reset values: dl_wait=0, rom_addr=0, rom_data=0, prog_we=0, gfx_we=0, game_reset=1, checksum=0, dl_done=0, dl_err=0. State=HOLD with hold counter=HOLD_CYCLES.
- States:
  - IDLE: game running.
  - LOAD: download active, waiting for a byte.
  - WRITE: strobe asserted.
  - HOLD: post-download reset.
- IDLE:
  - game_reset = rst_req, registered, 1-cycle latency.
  - dl_active rising -> LOAD. On that transition: clear checksum and dl_err, set game_reset=1.
- LOAD:
  - dl_wr=1, addr < PROG_BYTES: latch rom_addr=dl_addr[11:0] and rom_data; assert prog_we and dl_wait next cycle; go to WRITE.
  - dl_wr=1, PROG_BYTES <= addr < PROG_BYTES+GFX_BYTES: same, but rom_addr=dl_addr-PROG_BYTES and gfx_we asserted.
  - dl_wr=1, addr beyond both regions: byte dropped, dl_err set, no strobe, no wait; stay in LOAD.
  - dl_active falls -> HOLD with counter=HOLD_CYCLES.
- WRITE:
  - Strobe stays high exactly WR_CYCLES cycles. dl_wait is high for the same cycles.
  - On the cycle after the last strobe cycle: strobe=0, dl_wait=0, checksum += rom_data (8-bit wrap), return to LOAD.
  - dl_wr seen in WRITE: byte ignored, dl_err set (protocol violation).
  - dl_active falls in WRITE: the in-flight write still completes; then go directly to HOLD.
- HOLD:
  - game_reset=1. Counter decrements each cycle; at 0 -> IDLE.
  - dl_done is set when a download completes, i.e. at HOLD entry from LOAD/WRITE. The reset-time HOLD does not set it.
  - dl_active rising in HOLD -> LOAD with the LOAD-entry clears.
  - rst_req in HOLD has no extra effect.
- game_reset is 1 in LOAD, WRITE and HOLD regardless of rst_req.
- prog_we and gfx_we are never high simultaneously.
- Asynchronous reset mid-write: strobes drop immediately and all outputs return to reset values.
- rom_addr/rom_data are stable for the entire strobe window.

Test Plan:
1. Release reset with dl_active=0 -> game_reset high for HOLD_CYCLES (16) cycles, then 0. dl_done=0, checksum=0.
2. Download bytes 0x01,0x02,0x03 at addr 0,1,2, honouring dl_wait -> three prog_we pulses, each 2 cycles wide, rom_addr 0,1,2. After dl_active falls: checksum=0x06, dl_done=1, game_reset low 16 cycles later.
3. Byte 0xAA at addr 0x1005 -> gfx_we for 2 cycles with rom_addr=0x005, rom_data=0xAA. prog_we stays 0.
4. Byte at addr 0x1200 -> no strobe, no dl_wait, dl_err=1. Checksum unchanged. A new dl_active rising clears dl_err.
5. dl_wr pulsed during the second cycle of dl_wait -> byte ignored, dl_err=1, current write completes unaltered. Then 0xFF,0xFF at addr 0,1 -> checksum wraps to 0xFE.
6. Assert reset during a prog_we pulse -> prog_we=0 and dl_wait=0 in the same cycle, game_reset=1. rst_req pulse in IDLE -> game_reset follows one cycle later.
